// File: rtl/regfile_fwd_pkg.sv
// Shared constants and types for the forwarding register file.
// Defaults for widths, the hard-wired zero index and asserted enable levels.
package regfile_fwd_pkg;

    localparam int   DATA_W_DEF = 32;
    localparam int   ADDR_W_DEF = 5;
    localparam int   REG_ZERO   = 0;
    localparam logic RE_ON      = 1'b1;
    localparam logic WE_ON      = 1'b1;

    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_EX   = 2'd1,
        SRC_WB   = 2'd2,
        SRC_ARR  = 2'd3
    } rd_src_e;

endpackage

// File: rtl/regfile_read_mux.sv
// One read port: picks zero, EX forward, WB write-through or array data.
// Purely combinational, zero latency, never stalls.
module regfile_read_mux
    import regfile_fwd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter bit FWD_EX = 1'b1
) (
    input  logic              rst,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    input  logic [DATA_W-1:0] arr_dat_i,
    input  logic              ex_we_i,
    input  logic [ADDR_W-1:0] ex_waddr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    rd_src_e src;

    // EX is the younger instruction, so it outranks a same-cycle WB hit.
    always_comb begin
        src = SRC_ARR;
        if (!rst || re_i != RE_ON || raddr_i == ADDR_W'(REG_ZERO)) begin
            src = SRC_ZERO;
        end else if (FWD_EX && ex_we_i == WE_ON && ex_waddr_i == raddr_i) begin
            src = SRC_EX;
        end else if (we_i == WE_ON && waddr_i == raddr_i) begin
            src = SRC_WB;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (src)
            SRC_EX:  rdata_o = ex_wdata_i;
            SRC_WB:  rdata_o = wdata_i;
            SRC_ARR: rdata_o = arr_dat_i;
            default: rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/regfile_fwd.sv
// 32x32 register file with EX forwarding and WB write-through on two read ports.
// Reads are combinational (zero latency); writes land on the clock edge; no backpressure.
module regfile_fwd
    import regfile_fwd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter bit FWD_EX = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              ex_we_i,
    input  logic [ADDR_W-1:0] ex_waddr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Only the WB port updates state; EX is forwarding-only.
    always_comb begin
        mem_d = mem_q;
        if (we_i == WE_ON && waddr_i != ADDR_W'(REG_ZERO)) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    regfile_read_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .FWD_EX (FWD_EX)
    ) u_rd1 (
        .rst        (rst),
        .re_i       (re1_i),
        .raddr_i    (raddr1_i),
        .arr_dat_i  (mem_q[raddr1_i]),
        .ex_we_i    (ex_we_i),
        .ex_waddr_i (ex_waddr_i),
        .ex_wdata_i (ex_wdata_i),
        .we_i       (we_i),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata1_o)
    );

    regfile_read_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .FWD_EX (FWD_EX)
    ) u_rd2 (
        .rst        (rst),
        .re_i       (re2_i),
        .raddr_i    (raddr2_i),
        .arr_dat_i  (mem_q[raddr2_i]),
        .ex_we_i    (ex_we_i),
        .ex_waddr_i (ex_waddr_i),
        .ex_wdata_i (ex_wdata_i),
        .we_i       (we_i),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata2_o)
    );

endmodule

// File: tb/tb_regfile_fwd.sv
// Bench for regfile_fwd: forwarding and non-forwarding builds share stimulus.
module tb_regfile_fwd;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic        ex_we_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        re1_i;
    logic [4:0]  raddr1_i;
    logic        re2_i;
    logic [4:0]  raddr2_i;
    logic [31:0] rdata1_f, rdata2_f, rdata1_n, rdata2_n;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] model [32];

    regfile_fwd #(.DATA_W(32), .ADDR_W(5), .FWD_EX(1'b1)) dut_f (
        .clk(clk), .rst(rst),
        .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .re1_i(re1_i), .raddr1_i(raddr1_i), .rdata1_o(rdata1_f),
        .re2_i(re2_i), .raddr2_i(raddr2_i), .rdata2_o(rdata2_f)
    );

    regfile_fwd #(.DATA_W(32), .ADDR_W(5), .FWD_EX(1'b0)) dut_n (
        .clk(clk), .rst(rst),
        .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .re1_i(re1_i), .raddr1_i(raddr1_i), .rdata1_o(rdata1_n),
        .re2_i(re2_i), .raddr2_i(raddr2_i), .rdata2_o(rdata2_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Read result from the priority list, applied to architectural state.
    function automatic logic [31:0] ref_rd(input bit fwd, input logic re, input logic [4:0] a);
        if (!rst || !re || a == 5'd0) return 32'd0;
        if (fwd && ex_we_i && ex_waddr_i == a) return ex_wdata_i;
        if (we_i && waddr_i == a) return wdata_i;
        return model[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst && we_i && waddr_i != 5'd0) model[waddr_i] = wdata_i;
        #1;
    endtask

    task automatic set_rst(input logic v);
        rst = v;
        if (!v) clear_model();
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_f1"}, rdata1_f, ref_rd(1'b1, re1_i, raddr1_i));
        chk({tag, "_f2"}, rdata2_f, ref_rd(1'b1, re2_i, raddr2_i));
        chk({tag, "_n1"}, rdata1_n, ref_rd(1'b0, re1_i, raddr1_i));
        chk({tag, "_n2"}, rdata2_n, ref_rd(1'b0, re2_i, raddr2_i));
    endtask

    task automatic idle();
        we_i = 0; waddr_i = 0; wdata_i = 0;
        ex_we_i = 0; ex_waddr_i = 0; ex_wdata_i = 0;
    endtask

    initial begin
        idle();
        re1_i = 0; raddr1_i = 0; re2_i = 0; raddr2_i = 0;
        clear_model();
        rst = 1'b0;
        #2;

        // Writes during reset are discarded; reads are 0 while reset is low.
        we_i = 1; waddr_i = 5'd3; wdata_i = 32'hFFFF_FFFF;
        re1_i = 1; raddr1_i = 5'd3; re2_i = 1; raddr2_i = 5'd3;
        #1;
        chk("rst_rd1", rdata1_f, 32'd0);
        chk("rst_rd2", rdata2_n, 32'd0);
        repeat (3) tick();
        idle();
        set_rst(1'b1);
        chk("post_rst_r3_1", rdata1_f, 32'd0);
        chk("post_rst_r3_2", rdata2_n, 32'd0);

        // Basic write then read, second port disabled.
        we_i = 1; waddr_i = 5'd5; wdata_i = 32'hDEAD_BEEF;
        tick();
        idle();
        re1_i = 1; raddr1_i = 5'd5; re2_i = 0; raddr2_i = 5'd5;
        #1;
        chk("r5_p1_f", rdata1_f, 32'hDEAD_BEEF);
        chk("r5_p1_n", rdata1_n, 32'hDEAD_BEEF);
        chk("re2_off", rdata2_f, 32'd0);

        // Register zero ignores both WB and EX.
        we_i = 1; waddr_i = 5'd0; wdata_i = 32'hAAAA_5555;
        ex_we_i = 1; ex_waddr_i = 5'd0; ex_wdata_i = 32'h1;
        re1_i = 1; raddr1_i = 5'd0; re2_i = 1; raddr2_i = 5'd0;
        #1;
        chk("r0_pre_1", rdata1_f, 32'd0);
        chk("r0_pre_2", rdata2_f, 32'd0);
        tick();
        idle();
        #1;
        chk("r0_post_1", rdata1_f, 32'd0);
        chk("r0_post_2", rdata2_n, 32'd0);

        // WB write-through before the edge.
        we_i = 1; waddr_i = 5'd9; wdata_i = 32'h0000_00F0;
        re2_i = 1; raddr2_i = 5'd9;
        #1;
        chk("wt_r9_f", rdata2_f, 32'h0000_00F0);
        chk("wt_r9_n", rdata2_n, 32'h0000_00F0);
        tick();
        idle();

        // EX beats WB on reads; array still takes WB data.
        we_i = 1; waddr_i = 5'd4; wdata_i = 32'h1111_1111;
        tick();
        we_i = 1; waddr_i = 5'd4; wdata_i = 32'h2222_2222;
        ex_we_i = 1; ex_waddr_i = 5'd4; ex_wdata_i = 32'h3333_3333;
        re1_i = 1; raddr1_i = 5'd4; re2_i = 1; raddr2_i = 5'd4;
        #1;
        chk("exfwd_p1", rdata1_f, 32'h3333_3333);
        chk("exfwd_p2", rdata2_f, 32'h3333_3333);
        chk("nofwd_p1", rdata1_n, 32'h2222_2222);
        chk("nofwd_p2", rdata2_n, 32'h2222_2222);
        tick();
        idle();
        #1;
        chk("after_ex_f", rdata1_f, 32'h2222_2222);
        chk("after_ex_n", rdata2_n, 32'h2222_2222);

        // Asynchronous reset mid-run, then first write after release.
        we_i = 1; waddr_i = 5'd7; wdata_i = 32'h1234_5678;
        tick();
        idle();
        re1_i = 1; raddr1_i = 5'd7; re2_i = 1; raddr2_i = 5'd7;
        #1;
        chk("r7_before", rdata1_f, 32'h1234_5678);
        set_rst(1'b0);
        chk("r7_in_rst_1", rdata1_f, 32'd0);
        chk("r7_in_rst_2", rdata2_n, 32'd0);
        tick();
        set_rst(1'b1);
        chk("r7_cleared", rdata1_f, 32'd0);
        we_i = 1; waddr_i = 5'd7; wdata_i = 32'h0000_0055;
        tick();
        idle();
        #1;
        chk("r7_first_wr", rdata2_f, 32'h0000_0055);

        // Random traffic on a narrow address window to provoke collisions.
        for (int c = 0; c < 1500; c++) begin
            we_i       = ($urandom_range(0, 3) != 0);
            waddr_i    = 5'($urandom_range(0, 7));
            wdata_i    = $urandom;
            ex_we_i    = ($urandom_range(0, 1) != 0);
            ex_waddr_i = 5'($urandom_range(0, 7));
            ex_wdata_i = $urandom;
            re1_i      = ($urandom_range(0, 7) != 0);
            raddr1_i   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            re2_i      = ($urandom_range(0, 7) != 0);
            raddr2_i   = ($urandom_range(0, 2) == 0) ? raddr1_i : 5'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) set_rst(1'b0);
            else if (!rst) set_rst(1'b1);
            else #1;
            chk_model("rnd");
            if (rst && rdata1_f !== rdata2_f && re1_i && re2_i && raddr1_i == raddr2_i)
                chk("same_idx", rdata2_f, rdata1_f);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
